// File: rtl/packet_field_splitter_pkg.sv
// Shared types for the receive-path field splitter: parser states and end-of-packet status codes.
package splitter_pkg;

  typedef enum logic [1:0] {
    HDR   = 2'd0,
    PIX   = 2'd1,
    AUD   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ST_OK         = 2'd0,
    ST_SHORT      = 2'd1,
    ST_OVERFLOW   = 2'd2,
    ST_MISALIGNED = 2'd3
  } eop_status_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/packet_field_splitter_assembler.sv
// Packs MSB-first IN_W-bit beats into bytes; any pending partial byte is dropped when axiiv falls.
module beat_byte_assembler #(
  parameter int IN_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            axiiv_i,
  input  logic [IN_W-1:0] axiid_i,
  output logic            byte_done_o,
  output logic [7:0]      byte_out_o,
  output logic            partial_o
);

  localparam int BEATS = 8 / IN_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [7:0]    sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_beat;

  assign last_beat   = (cnt_q == CW'(BEATS - 1));
  assign byte_done_o = axiiv_i && last_beat;
  assign byte_out_o  = sr_d;
  assign partial_o   = (cnt_q != '0);

  always_comb begin
    sr_d  = 8'({sr_q, axiid_i});
    cnt_d = last_beat ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || !axiiv_i) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/packet_field_splitter.sv
// Splits the assembled byte stream into header, fixed pixel segment and bounded audio segment,
// with a registered per-packet status pulse.
module packet_field_splitter
  import splitter_pkg::*;
#(
  parameter int IN_W          = 2,
  parameter int HDR_BYTES     = 3,
  parameter int PIX_BYTES     = 320,
  parameter int AUD_MAX_BYTES = 64,
  localparam int HDR_W  = 8 * HDR_BYTES,
  localparam int PIX_IW = $clog2(PIX_BYTES + 1),
  localparam int AUD_IW = (AUD_MAX_BYTES > 0) ? $clog2(AUD_MAX_BYTES + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [IN_W-1:0]   axiid,
  output logic              hdr_valid,
  output logic [HDR_W-1:0]  hdr,
  output logic              pix_valid,
  output logic [7:0]        pix_byte,
  output logic [PIX_IW-1:0] pix_idx,
  output logic              aud_valid,
  output logic [7:0]        aud_byte,
  output logic [AUD_IW-1:0] aud_idx,
  output logic              eop_valid,
  output logic [1:0]        eop_status
);

  localparam int CNT_W = $clog2(max3(HDR_BYTES, PIX_BYTES, AUD_MAX_BYTES) + 1);

  logic       byte_done, partial;
  logic [7:0] byte_val;

  beat_byte_assembler #(.IN_W(IN_W)) u_asm (
    .clk        (clk),
    .rst        (rst),
    .axiiv_i    (axiiv),
    .axiid_i    (axiid),
    .byte_done_o(byte_done),
    .byte_out_o (byte_val),
    .partial_o  (partial)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_pkt_q, in_pkt_d;
  logic              ovf_q, ovf_d;
  logic [HDR_W-1:0]  hdr_sr_q, hdr_sr_d;
  logic              hdr_valid_q, hdr_valid_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic              pix_valid_q, pix_valid_d;
  logic [7:0]        pix_byte_q, pix_byte_d;
  logic [PIX_IW-1:0] pix_idx_q, pix_idx_d;
  logic              aud_valid_q, aud_valid_d;
  logic [7:0]        aud_byte_q, aud_byte_d;
  logic [AUD_IW-1:0] aud_idx_q, aud_idx_d;
  logic              eop_valid_q, eop_valid_d;
  eop_status_e       eop_status_q, eop_status_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_pkt_d     = in_pkt_q;
    ovf_d        = ovf_q;
    hdr_sr_d     = hdr_sr_q;
    hdr_valid_d  = 1'b0;
    hdr_d        = hdr_q;
    pix_valid_d  = 1'b0;
    pix_byte_d   = pix_byte_q;
    pix_idx_d    = pix_idx_q;
    aud_valid_d  = 1'b0;
    aud_byte_d   = aud_byte_q;
    aud_idx_d    = aud_idx_q;
    eop_valid_d  = 1'b0;
    eop_status_d = eop_status_q;

    if (axiiv) begin
      in_pkt_d = 1'b1;
      if (byte_done) begin
        unique case (state_q)
          HDR: begin
            hdr_sr_d = HDR_W'({hdr_sr_q, byte_val});
            if (cnt_q == CNT_W'(HDR_BYTES - 1)) begin
              hdr_d       = hdr_sr_d;
              hdr_valid_d = 1'b1;
              cnt_d       = '0;
              state_d     = PIX;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          PIX: begin
            pix_valid_d = 1'b1;
            pix_byte_d  = byte_val;
            pix_idx_d   = PIX_IW'(cnt_q);
            if (cnt_q == CNT_W'(PIX_BYTES - 1)) begin
              cnt_d   = '0;
              state_d = (AUD_MAX_BYTES == 0) ? DRAIN : AUD;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          AUD: begin
            // Audio counter saturates at the limit; the next byte is swallowed as overflow.
            if (cnt_q == CNT_W'(AUD_MAX_BYTES)) begin
              ovf_d   = 1'b1;
              state_d = DRAIN;
            end else begin
              aud_valid_d = 1'b1;
              aud_byte_d  = byte_val;
              aud_idx_d   = AUD_IW'(cnt_q);
              cnt_d       = cnt_q + 1'b1;
            end
          end
          DRAIN: ovf_d = 1'b1;
          default: ;
        endcase
      end
    end else if (in_pkt_q) begin
      eop_valid_d = 1'b1;
      if (ovf_q)                                eop_status_d = ST_OVERFLOW;
      else if (state_q == HDR || state_q == PIX) eop_status_d = ST_SHORT;
      else if (partial)                         eop_status_d = ST_MISALIGNED;
      else                                      eop_status_d = ST_OK;
      state_d  = HDR;
      cnt_d    = '0;
      in_pkt_d = 1'b0;
      ovf_d    = 1'b0;
      hdr_sr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HDR;
      cnt_q        <= '0;
      in_pkt_q     <= 1'b0;
      ovf_q        <= 1'b0;
      hdr_sr_q     <= '0;
      hdr_valid_q  <= 1'b0;
      hdr_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_byte_q   <= '0;
      pix_idx_q    <= '0;
      aud_valid_q  <= 1'b0;
      aud_byte_q   <= '0;
      aud_idx_q    <= '0;
      eop_valid_q  <= 1'b0;
      eop_status_q <= ST_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_pkt_q     <= in_pkt_d;
      ovf_q        <= ovf_d;
      hdr_sr_q     <= hdr_sr_d;
      hdr_valid_q  <= hdr_valid_d;
      hdr_q        <= hdr_d;
      pix_valid_q  <= pix_valid_d;
      pix_byte_q   <= pix_byte_d;
      pix_idx_q    <= pix_idx_d;
      aud_valid_q  <= aud_valid_d;
      aud_byte_q   <= aud_byte_d;
      aud_idx_q    <= aud_idx_d;
      eop_valid_q  <= eop_valid_d;
      eop_status_q <= eop_status_d;
    end
  end

  assign hdr_valid  = hdr_valid_q;
  assign hdr        = hdr_q;
  assign pix_valid  = pix_valid_q;
  assign pix_byte   = pix_byte_q;
  assign pix_idx    = pix_idx_q;
  assign aud_valid  = aud_valid_q;
  assign aud_byte   = aud_byte_q;
  assign aud_idx    = aud_idx_q;
  assign eop_valid  = eop_valid_q;
  assign eop_status = eop_status_q;

endmodule

// File: tb/tb_packet_field_splitter.sv
// Scoreboard bench: a default-parameter splitter (A) and a byte-wide, no-audio splitter (B).
module tb_packet_field_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, av_a, rst_b, av_b;
  logic [1:0] ad_a;
  logic [7:0] ad_b;

  logic        hdr_valid_a, pix_valid_a, aud_valid_a, eop_valid_a;
  logic [23:0] hdr_a;
  logic [7:0]  pix_byte_a, aud_byte_a;
  logic [8:0]  pix_idx_a;
  logic [6:0]  aud_idx_a;
  logic [1:0]  eop_status_a;

  logic        hdr_valid_b, pix_valid_b, aud_valid_b, eop_valid_b;
  logic [23:0] hdr_b;
  logic [7:0]  pix_byte_b, aud_byte_b;
  logic [2:0]  pix_idx_b;
  logic        aud_idx_b;
  logic [1:0]  eop_status_b;

  packet_field_splitter u_dut_a (
    .clk(clk), .rst(rst_a), .axiiv(av_a), .axiid(ad_a),
    .hdr_valid(hdr_valid_a), .hdr(hdr_a),
    .pix_valid(pix_valid_a), .pix_byte(pix_byte_a), .pix_idx(pix_idx_a),
    .aud_valid(aud_valid_a), .aud_byte(aud_byte_a), .aud_idx(aud_idx_a),
    .eop_valid(eop_valid_a), .eop_status(eop_status_a)
  );

  packet_field_splitter #(.IN_W(8), .HDR_BYTES(3), .PIX_BYTES(4), .AUD_MAX_BYTES(0)) u_dut_b (
    .clk(clk), .rst(rst_b), .axiiv(av_b), .axiid(ad_b),
    .hdr_valid(hdr_valid_b), .hdr(hdr_b),
    .pix_valid(pix_valid_b), .pix_byte(pix_byte_b), .pix_idx(pix_idx_b),
    .aud_valid(aud_valid_b), .aud_byte(aud_byte_b), .aud_idx(aud_idx_b),
    .eop_valid(eop_valid_b), .eop_status(eop_status_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  int hdrq_a[$], pixq_a[$], audq_a[$], eopq_a[$];
  int hdrq_b[$], pixq_b[$], eopq_b[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(input int i, input int seed, input logic [23:0] h);
    if (i < 3) return h[23 - 8*i -: 8];
    return 8'(i * 37 + seed);
  endfunction

  // Expected results derived from packet shape alone.
  task automatic model(input int which, input int nbytes, input int extra, input int seed,
                       input logic [23:0] h);
    int p, a, st, k;
    p = (which == 0) ? 320 : 4;
    a = (which == 0) ? 64 : 0;
    if (nbytes >= 3) begin
      if (which == 0) hdrq_a.push_back(int'(h)); else hdrq_b.push_back(int'(h));
    end
    for (int i = 3; i < nbytes; i++) begin
      k = i - 3;
      if (k < p) begin
        if (which == 0) pixq_a.push_back((k << 8) | int'(pkt_byte(i, seed, h)));
        else            pixq_b.push_back((k << 8) | int'(pkt_byte(i, seed, h)));
      end else if (k - p < a) begin
        audq_a.push_back(((k - p) << 8) | int'(pkt_byte(i, seed, h)));
      end
    end
    if (nbytes > 3 + p + a)  st = 2;
    else if (nbytes < 3 + p) st = 1;
    else if (extra > 0)      st = 3;
    else                     st = 0;
    if (which == 0) eopq_a.push_back(st); else eopq_b.push_back(st);
  endtask

  task automatic beat(input int which, input int v);
    @(posedge clk); #1;
    if (which == 0) begin av_a = 1'b1; ad_a = 2'(v); end
    else            begin av_b = 1'b1; ad_b = 8'(v); end
  endtask

  task automatic idle(input int which);
    @(posedge clk); #1;
    if (which == 0) av_a = 1'b0; else av_b = 1'b0;
  endtask

  task automatic drive_bytes(input int which, input int nbytes, input int seed, input logic [23:0] h);
    int w, b;
    w = (which == 0) ? 2 : 8;
    for (int i = 0; i < nbytes; i++) begin
      b = int'(pkt_byte(i, seed, h));
      for (int k = 0; k < 8 / w; k++)
        beat(which, (b >> (8 - w * (k + 1))) & ((1 << w) - 1));
    end
  endtask

  task automatic send(input int which, input int nbytes, input int extra, input int seed,
                      input logic [23:0] h);
    model(which, nbytes, extra, seed, h);
    drive_bytes(which, nbytes, seed, h);
    for (int e = 0; e < extra; e++) beat(which, 1);
    idle(which);
  endtask

  task automatic check_zero_a(input string pfx);
    check({pfx, "_flags"}, 32'({hdr_valid_a, pix_valid_a, aud_valid_a, eop_valid_a, eop_status_a}), 0);
    check({pfx, "_hdr"}, 32'(hdr_a), 0);
    check({pfx, "_pix"}, 32'({pix_idx_a, pix_byte_a}), 0);
    check({pfx, "_aud"}, 32'({aud_idx_a, aud_byte_a}), 0);
  endtask

  always @(negedge clk) begin
    if (hdr_valid_a) begin
      if (hdrq_a.size() == 0) check("hdr_a_unexpected", 1, 0);
      else check("hdr_a", 32'(hdr_a), hdrq_a.pop_front());
    end
    if (pix_valid_a) begin
      if (pixq_a.size() == 0) check("pix_a_unexpected", 1, 0);
      else check("pix_a", 32'({pix_idx_a, pix_byte_a}), pixq_a.pop_front());
    end
    if (aud_valid_a) begin
      if (audq_a.size() == 0) check("aud_a_unexpected", 1, 0);
      else check("aud_a", 32'({aud_idx_a, aud_byte_a}), audq_a.pop_front());
    end
    if (eop_valid_a) begin
      if (eopq_a.size() == 0) check("eop_a_unexpected", 1, 0);
      else check("eop_a", 32'(eop_status_a), eopq_a.pop_front());
    end
  end

  int cyc_b = 0;
  int last_pix_b = -10;
  int adj_b = 0;

  always @(negedge clk) begin
    cyc_b++;
    if (hdr_valid_b) begin
      if (hdrq_b.size() == 0) check("hdr_b_unexpected", 1, 0);
      else check("hdr_b", 32'(hdr_b), hdrq_b.pop_front());
    end
    if (pix_valid_b) begin
      if (cyc_b == last_pix_b + 1) adj_b++;
      last_pix_b = cyc_b;
      if (pixq_b.size() == 0) check("pix_b_unexpected", 1, 0);
      else check("pix_b", 32'({pix_idx_b, pix_byte_b}), pixq_b.pop_front());
    end
    if (aud_valid_b) check("aud_b_unexpected", 1, 0);
    if (eop_valid_b) begin
      if (eopq_b.size() == 0) check("eop_b_unexpected", 1, 0);
      else check("eop_b", 32'(eop_status_b), eopq_b.pop_front());
    end
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    av_a = 1'b0; av_b = 1'b0; ad_a = '0; ad_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero_a("reset");
    check("reset_b", 32'({hdr_valid_b, pix_valid_b, eop_valid_b, hdr_b, eop_status_b}), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (3) idle(0);

    send(0, 339, 0, 5,  24'hABCDEF);
    send(0, 103, 0, 11, 24'h123456);
    send(0, 339, 0, 17, 24'h654321);
    send(0, 393, 0, 23, 24'h0F1E2D);
    send(0, 328, 1, 29, 24'hC0FFEE);

    send(1, 7, 0, 3, 24'h010203);
    send(1, 8, 0, 9, 24'hA1B2C3);
    repeat (3) idle(1);

    // Abort mid-pixel: only the header and 10 pixel bytes are expected, then no eop.
    hdrq_a.push_back(int'(24'h5A5A5A));
    for (int k = 0; k < 10; k++)
      pixq_a.push_back((k << 8) | int'(pkt_byte(k + 3, 41, 24'h5A5A5A)));
    drive_bytes(0, 13, 41, 24'h5A5A5A);
    beat(0, 2);
    @(posedge clk); #1; rst_a = 1'b1;
    @(posedge clk); #1; rst_a = 1'b0; av_a = 1'b0;
    check_zero_a("abort");
    repeat (4) idle(0);
    send(0, 339, 0, 47, 24'hABCDEF);

    repeat (10) @(posedge clk);
    #1;
    check("b_adjacent_pix", 32'(adj_b), 6);
    check("left_hdr_a", 32'(hdrq_a.size()), 0);
    check("left_pix_a", 32'(pixq_a.size()), 0);
    check("left_aud_a", 32'(audq_a.size()), 0);
    check("left_eop_a", 32'(eopq_a.size()), 0);
    check("left_hdr_b", 32'(hdrq_b.size()), 0);
    check("left_pix_b", 32'(pixq_b.size()), 0);
    check("left_eop_b", 32'(eopq_b.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
